// File: rtl/add_sub_unfan_if.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_unfan_if
// Purpose  : Valid/ready stream bundle between a sum/difference producer,
//            the add_sub_unfan decoder and its downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface add_sub_unfan_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH:0]   diff_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             err;
    logic [7:0]       err_count;

    modport slave (
        input  in_valid, sum_in, diff_in, out_ready,
        output in_ready, out_valid, out0, out1, err, err_count
    );

    modport master (
        output in_valid, sum_in, diff_in, out_ready,
        input  in_ready, out_valid, out0, out1, err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/add_sub_unfan.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_unfan
// Purpose  : Two-stage decoder recovering (in0, in1) from sum/difference,
//            flagging impossible pairs. ADD_SUB_UNFAN_ERRCNT_EN builds the
//            saturating error counter; otherwise err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_unfan #(
    parameter int WIDTH = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    add_sub_unfan_if.slave   bus
);
    localparam int c_XW = WIDTH + 2;

    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_sum;
    logic [WIDTH:0]   r_s1_diff;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic             r_err;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic [c_XW-1:0]  w_sum_x;
    logic [c_XW-1:0]  w_diff_x;
    logic [c_XW-1:0]  w_a;
    logic [c_XW-1:0]  w_b;
    logic             w_par_err;
    logic             w_rng_err;

    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;

    assign w_sum_x  = {1'b0, r_s1_sum};
    assign w_diff_x = {r_s1_diff[WIDTH], r_s1_diff};
    assign w_a      = $signed(w_sum_x + w_diff_x) >>> 1;
    assign w_b      = $signed(w_sum_x - w_diff_x) >>> 1;

    // Odd sum+diff has no integer half; any bit above WIDTH means a negative
    // or oversized operand (this also catches wrap of the WIDTH+2 sum).
    assign w_par_err = r_s1_sum[0] ^ r_s1_diff[0];
    assign w_rng_err = (|w_a[c_XW-1:WIDTH]) || (|w_b[c_XW-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_diff  <= '0;
            r_s2_valid <= 1'b0;
            r_out0     <= '0;
            r_out1     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_sum  <= bus.sum_in;
                    r_s1_diff <= bus.diff_in;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out0 <= w_a[WIDTH-1:0];
                    r_out1 <= w_b[WIDTH-1:0];
                    r_err  <= w_par_err || w_rng_err;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out0      = r_out0;
    assign bus.out1      = r_out1;
    assign bus.err       = r_err;

`ifdef ADD_SUB_UNFAN_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (r_s2_valid && bus.out_ready && r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_sub_unfan.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sub_unfan
// Purpose  : Directed self-checking bench for add_sub_unfan (WIDTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_unfan;
    localparam int W = 2;
`ifdef ADD_SUB_UNFAN_ERRCNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] o0;
        logic [W-1:0] o1;
        logic         e;
        int           stamp;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   exp_cnt = 0;
    beat_t q[$];

    add_sub_unfan_if #(.WIDTH(W)) bus ();

    add_sub_unfan #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operands as true integers: a and b must be whole and inside 0..2^W-1.
    function automatic beat_t model(input logic [W:0] s, input logic [W:0] d);
        beat_t r;
        int sv, dv, a2, b2, a, b;
        sv = int'(s);
        dv = int'($signed(d));
        a2 = sv + dv;
        b2 = sv - dv;
        a  = a2 >>> 1;
        b  = b2 >>> 1;
        r.o0 = a[W-1:0];
        r.o1 = b[W-1:0];
        r.e  = ((a2 % 2) != 0) || (a < 0) || (a > (1 << W) - 1) || (b < 0) || (b > (1 << W) - 1);
        r.stamp = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            bit    exp_valid;
            beat_t nb;
            exp_valid = (q.size() > 0) && (q[0].stamp < cyc);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
            if (bus.out_valid && exp_valid) begin
                chk("out0", 32'(bus.out0), 32'(q[0].o0));
                chk("out1", 32'(bus.out1), 32'(q[0].o1));
                chk("err", 32'(bus.err), 32'(q[0].e));
            end
            chk("err_count", 32'(bus.err_count), 32'(exp_cnt));
            if (rst) begin
                q.delete();
                exp_cnt = 0;
            end else begin
                if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                    if (q[0].e && c_CNT_EN && exp_cnt < 255) exp_cnt++;
                    void'(q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    nb = model(bus.sum_in, bus.diff_in);
                    nb.stamp = cyc + 1;
                    q.push_back(nb);
                end
            end
        end
    end

    // Holds in_valid high on return so consecutive calls stream back-to-back.
    task automatic send(input logic [W:0] s, input logic [W:0] d);
        bit ok;
        int t;
        bus.sum_in   = s;
        bus.diff_in  = d;
        bus.in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready && !rst;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 100);
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        beat_t m;
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.diff_in   = '0;
        bus.out_ready = 1'b1;

        m = model(3'b100, 3'b010);
        chk("model_4_2", {29'd0, m.o0, m.o1, m.e}, {29'd0, 2'd3, 2'd1, 1'b0});
        m = model(3'b100, 3'b110);
        chk("model_4_m2", {29'd0, m.o0, m.o1, m.e}, {29'd0, 2'd1, 2'd3, 1'b0});
        m = model(3'b011, 3'b000);
        chk("model_parity", 32'(m.e), 32'd1);
        m = model(3'b110, 3'b110);
        chk("model_range", {29'd0, m.o0, m.o1, m.e}, {29'd0, 2'd2, 2'd0, 1'b1});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out0", 32'(bus.out0), 32'd0);
        chk("rst_out1", 32'(bus.out1), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);

        // Latency: accept at edge N, visible after edge N+1.
        @(posedge clk);
        #1;
        send(3'b100, 3'b010);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_out", {30'd0, bus.out0, bus.out1, bus.err}, {29'd0, 2'd3, 2'd1, 1'b0});
        drain();

        send(3'b100, 3'b110);
        send(3'b000, 3'b000);
        drain();

        send(3'b011, 3'b000);
        send(3'b110, 3'b110);
        drain();
        @(negedge clk);
        chk("cnt_after_two", 32'(bus.err_count), c_CNT_EN ? 32'd2 : 32'd0);

        // Backpressure: third beat must wait while both stages are full.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(3'b100, 3'b010);
        send(3'b100, 3'b110);
        bus.sum_in  = 3'b010;
        bus.diff_in = 3'b000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold", {29'd0, bus.out_valid, bus.out0, bus.out1}, {29'd0, 1'b1, 2'd3, 2'd1});
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_d0", {29'd0, bus.out_valid, bus.out0, bus.out1}, {29'd0, 1'b1, 2'd3, 2'd1});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_d1", {29'd0, bus.out_valid, bus.out0, bus.out1}, {29'd0, 1'b1, 2'd1, 2'd3});
        @(negedge clk);
        chk("bp_d2", {29'd0, bus.out_valid, bus.out0, bus.out1}, {29'd0, 1'b1, 2'd1, 2'd1});
        drain();

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        send(3'b011, 3'b000);
        send(3'b110, 3'b110);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bus.err_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out0", 32'(bus.out0), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        for (int i = 0; i < 300; i++) send(3'b011, 3'b000);
        drain();
        @(negedge clk);
        chk("sat_cnt", 32'(bus.err_count), c_CNT_EN ? 32'd255 : 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(3'b001, 3'b000);
        drain();
        @(negedge clk);
        chk("sat_hold", 32'(bus.err_count), c_CNT_EN ? 32'd255 : 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
